timerio: RTL and testbench

//  16-bit programmable interval timer peripheral on the 6801 system bus at DS1 ($E620-$E62F).

---
 rtl/timerio.sv | 154 +++++++++++++++
 tb/tb_timerio.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timerio.sv
// timerio: 16-bit programmable interval timer on the 6801 bus, with prescaler, W1C status and level irq.
// Optional input capture is built when TIMERIO_CAPTURE_EN is defined (adds the cap_in port).
module timerio #(
  parameter logic [7:0]  PRESC_RESET  = 8'h00,
  parameter logic [15:0] RELOAD_RESET = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst,
  output logic       irq,
  input  logic [3:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs
`ifdef TIMERIO_CAPTURE_EN
  ,
  input  logic       cap_in
`endif
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

`ifdef TIMERIO_CAPTURE_EN
  localparam logic [4:1] CFG_MASK = 4'b1111;
`else
  localparam logic [4:1] CFG_MASK = 4'b0011;
`endif

  state_t      state, next_state;
  logic [4:1]  cfg;
  logic [1:0]  status;
  logic [1:0]  status_clr;
  logic [7:0]  presc;
  logic [7:0]  pcnt;
  logic [7:0]  rel_latch;
  logic [7:0]  snap;
  logic [15:0] reload;
  logic [15:0] count;
  logic [15:0] count_next;
  logic [15:0] cap;
  logic        tick;
  logic        ovf_evt;
  logic        cap_evt;

  logic wr, rd;
  logic wr_ctrl, wr_status, wr_presc, wr_relh, wr_rell, rd_cnth;

  assign wr        = cs & ~rw;
  assign rd        = cs & rw;
  assign wr_ctrl   = wr && (AD == 4'd0);
  assign wr_status = wr && (AD == 4'd1);
  assign wr_presc  = wr && (AD == 4'd2);
  assign wr_relh   = wr && (AD == 4'd3);
  assign wr_rell   = wr && (AD == 4'd4);
  assign rd_cnth   = rd && (AD == 4'd5);

  assign status_clr = wr_status ? DI[1:0] : 2'b00;
  assign tick       = (state == RUN) && (pcnt == presc);

  // The EN bit of CTRL is the FSM state itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (wr_ctrl)
      next_state = DI[0] ? RUN : IDLE;
    else if (state == RUN && tick && count == 16'd0 && cfg[2] && !wr_rell)
      next_state = IDLE;
  end

  // A RELL write overrides whatever the tick would have done this cycle.
  always_comb begin
    count_next = count;
    ovf_evt    = 1'b0;
    if (wr_rell) begin
      count_next = {rel_latch, DI};
    end else if (state == RUN && tick) begin
      if (count != 16'd0) begin
        count_next = count - 16'd1;
      end else begin
        ovf_evt    = 1'b1;
        count_next = cfg[2] ? 16'd0 : reload;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg       <= '0;
      status    <= '0;
      presc     <= PRESC_RESET;
      pcnt      <= '0;
      rel_latch <= '0;
      reload    <= RELOAD_RESET;
      count     <= '0;
      snap      <= '0;
      irq       <= 1'b0;
    end else begin
      if (wr_ctrl)  cfg       <= DI[4:1] & CFG_MASK;
      if (wr_presc) presc     <= DI;
      if (wr_relh)  rel_latch <= DI;
      if (wr_rell)  reload    <= {rel_latch, DI};
      if (rd_cnth)  snap      <= count[7:0];
      // Hardware set beats a simultaneous write-1-to-clear.
      status <= (status & ~status_clr) | {cap_evt, ovf_evt};
      count  <= count_next;
      if (wr_rell || state != RUN || tick) pcnt <= 8'd0;
      else                                 pcnt <= pcnt + 8'd1;
      irq <= |(status & {cfg[3], cfg[1]});
    end
  end

`ifdef TIMERIO_CAPTURE_EN
  logic [2:0] cap_sync;
  logic       cap_edge;

  // Two synchroniser stages plus one history stage for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cap_sync <= '0;
    else      cap_sync <= {cap_sync[1:0], cap_in};
  end

  assign cap_edge = cfg[4] ? (~cap_sync[1] & cap_sync[2]) : (cap_sync[1] & ~cap_sync[2]);
  assign cap_evt  = cap_edge && (state == RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         cap <= '0;
    else if (cap_evt) cap <= count;
  end
`else
  assign cap_evt = 1'b0;
  assign cap     = '0;
`endif

  always_comb begin
    DO = 8'hFF;
    case (AD)
      4'd0:    DO = {3'b000, cfg, (state == RUN)};
      4'd1:    DO = {6'b000000, status};
      4'd2:    DO = presc;
      4'd3:    DO = reload[15:8];
      4'd4:    DO = reload[7:0];
      4'd5:    DO = count[15:8];
      4'd6:    DO = snap;
      4'd7:    DO = cap[15:8];
      4'd8:    DO = cap[7:0];
      default: DO = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_timerio.sv
// tb_timerio: directed self-checking bench for timerio; capture scenario built only with TIMERIO_CAPTURE_EN.
`timescale 1ns/1ps
module tb_timerio;

  localparam logic [3:0] A_CTRL = 4'd0, A_STAT = 4'd1, A_PRESC = 4'd2, A_RELH = 4'd3,
                         A_RELL = 4'd4, A_CNTH = 4'd5, A_CNTL = 4'd6, A_CAPH = 4'd7,
                         A_CAPL = 4'd8;

  logic       clk = 1'b0;
  logic       rst;
  logic       irq;
  logic [3:0] AD;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       rw;
  logic       cs;
`ifdef TIMERIO_CAPTURE_EN
  logic       cap_in;
`endif

  int pass_cnt  = 0;
  int check_cnt = 0;

  timerio dut (
    .clk (clk),
    .rst (rst),
    .irq (irq),
    .AD  (AD),
    .DI  (DI),
    .DO  (DO),
    .rw  (rw),
    .cs  (cs)
`ifdef TIMERIO_CAPTURE_EN
    ,
    .cap_in(cap_in)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [3:0] a, output logic [7:0] d);
    AD = a;
    #1;
    d = DO;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b0; AD = a; DI = d;
    @(posedge clk);
    #1;
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    cs = 1'b1; rw = 1'b1; AD = a;
    #1;
    d = DO;
    @(posedge clk);
    #1;
    cs = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    peek(A_CTRL, d);  check_cnt++; if (d !== 8'h00) $display("[TB] FAIL reset_ctrl got %h want 00", d); else pass_cnt++;
    peek(A_STAT, d);  check_cnt++; if (d !== 8'h00) $display("[TB] FAIL reset_status got %h want 00", d); else pass_cnt++;
    peek(A_PRESC, d); check_cnt++; if (d !== 8'h00) $display("[TB] FAIL reset_presc got %h want 00", d); else pass_cnt++;
    tick(1);
    peek(A_RELH, d);  check_cnt++; if (d !== 8'hFF) $display("[TB] FAIL reset_relh got %h want FF", d); else pass_cnt++;
    peek(A_RELL, d);  check_cnt++; if (d !== 8'hFF) $display("[TB] FAIL reset_rell got %h want FF", d); else pass_cnt++;
    peek(4'd9, d);    check_cnt++; if (d !== 8'hFF) $display("[TB] FAIL unmapped_reg got %h want FF", d); else pass_cnt++;
    tick(1);
    bus_read(A_CNTH, d); check_cnt++; if (d !== 8'h00) $display("[TB] FAIL reset_cnth got %h want 00", d); else pass_cnt++;
    bus_read(A_CNTL, d); check_cnt++; if (d !== 8'h00) $display("[TB] FAIL reset_cntl got %h want 00", d); else pass_cnt++;
    check_cnt++; if (irq !== 1'b0) $display("[TB] FAIL reset_irq got %b want 0", irq); else pass_cnt++;
  endtask

  task automatic test_periodic;
    logic [7:0] d;
    bus_write(A_PRESC, 8'h03);
    bus_write(A_RELH, 8'h00);
    bus_write(A_RELL, 8'h04);
    bus_write(A_CTRL, 8'h03);
    tick(19);
    peek(A_STAT, d); check_cnt++; if (d !== 8'h00) $display("[TB] FAIL per_status_early got %h want 00", d); else pass_cnt++;
    check_cnt++; if (irq !== 1'b0) $display("[TB] FAIL per_irq_early got %b want 0", irq); else pass_cnt++;
    tick(1);
    peek(A_STAT, d); check_cnt++; if (d !== 8'h01) $display("[TB] FAIL per_ovf_at_20 got %h want 01", d); else pass_cnt++;
    check_cnt++; if (irq !== 1'b0) $display("[TB] FAIL per_irq_same_clk got %b want 0", irq); else pass_cnt++;
    tick(1);
    check_cnt++; if (irq !== 1'b1) $display("[TB] FAIL per_irq_at_21 got %b want 1", irq); else pass_cnt++;
    bus_write(A_STAT, 8'h01);
    tick(1);
    check_cnt++; if (irq !== 1'b0) $display("[TB] FAIL per_irq_cleared got %b want 0", irq); else pass_cnt++;
    tick(16);
    peek(A_STAT, d); check_cnt++; if (d !== 8'h00) $display("[TB] FAIL per_status_before_40 got %h want 00", d); else pass_cnt++;
    tick(1);
    peek(A_STAT, d); check_cnt++; if (d !== 8'h01) $display("[TB] FAIL per_ovf_at_40 got %h want 01", d); else pass_cnt++;
    tick(1);
    check_cnt++; if (irq !== 1'b1) $display("[TB] FAIL per_irq_at_41 got %b want 1", irq); else pass_cnt++;
    bus_write(A_CTRL, 8'h00);
    bus_write(A_STAT, 8'h03);
    tick(2);
  endtask

  task automatic test_oneshot;
    logic [7:0] d;
    bus_write(A_RELL, 8'h04);
    bus_write(A_CTRL, 8'h07);
    tick(20);
    peek(A_CTRL, d); check_cnt++; if (d !== 8'h06) $display("[TB] FAIL os_ctrl got %h want 06", d); else pass_cnt++;
    peek(A_STAT, d); check_cnt++; if (d !== 8'h01) $display("[TB] FAIL os_status got %h want 01", d); else pass_cnt++;
    tick(1);
    check_cnt++; if (irq !== 1'b1) $display("[TB] FAIL os_irq got %b want 1", irq); else pass_cnt++;
    bus_read(A_CNTH, d); check_cnt++; if (d !== 8'h00) $display("[TB] FAIL os_cnth got %h want 00", d); else pass_cnt++;
    bus_read(A_CNTL, d); check_cnt++; if (d !== 8'h00) $display("[TB] FAIL os_cntl got %h want 00", d); else pass_cnt++;
    bus_write(A_STAT, 8'h01);
    tick(40);
    peek(A_STAT, d); check_cnt++; if (d !== 8'h00) $display("[TB] FAIL os_no_reovf got %h want 00", d); else pass_cnt++;
    check_cnt++; if (irq !== 1'b0) $display("[TB] FAIL os_irq_quiet got %b want 0", irq); else pass_cnt++;
    bus_write(A_CTRL, 8'h00);
  endtask

  task automatic test_w1c_collision;
    logic [7:0] d;
    bus_write(A_RELL, 8'h04);
    bus_write(A_CTRL, 8'h03);
    tick(19);
    bus_write(A_STAT, 8'h01);
    peek(A_STAT, d); check_cnt++; if (d !== 8'h01) $display("[TB] FAIL w1c_set_wins got %h want 01", d); else pass_cnt++;
    tick(1);
    check_cnt++; if (irq !== 1'b1) $display("[TB] FAIL w1c_irq_up got %b want 1", irq); else pass_cnt++;
    bus_write(A_STAT, 8'h01);
    peek(A_STAT, d); check_cnt++; if (d !== 8'h00) $display("[TB] FAIL w1c_quiet_clear got %h want 00", d); else pass_cnt++;
    tick(1);
    check_cnt++; if (irq !== 1'b0) $display("[TB] FAIL w1c_irq_drop got %b want 0", irq); else pass_cnt++;
    bus_write(A_CTRL, 8'h00);
    bus_write(A_STAT, 8'h03);
  endtask

  task automatic test_snapshot;
    logic [7:0] d;
    bus_write(A_PRESC, 8'h03);
    bus_write(A_RELH, 8'h12);
    bus_write(A_RELL, 8'h34);
    bus_write(A_CTRL, 8'h01);
    tick(21);
    bus_read(A_CNTH, d); check_cnt++; if (d !== 8'h12) $display("[TB] FAIL snap_cnth got %h want 12", d); else pass_cnt++;
    tick(10);
    bus_read(A_CNTL, d); check_cnt++; if (d !== 8'h2F) $display("[TB] FAIL snap_cntl got %h want 2F", d); else pass_cnt++;
    peek(A_RELH, d); check_cnt++; if (d !== 8'h12) $display("[TB] FAIL snap_relh got %h want 12", d); else pass_cnt++;
    bus_write(A_CTRL, 8'h00);
  endtask

  task automatic test_rell_vs_tick;
    logic [7:0] d;
    bus_write(A_PRESC, 8'h00);
    bus_write(A_RELH, 8'h00);
    bus_write(A_RELL, 8'h40);
    bus_write(A_CTRL, 8'h01);
    tick(3);
    bus_write(A_RELL, 8'h10);
    bus_read(A_CNTH, d); check_cnt++; if (d !== 8'h00) $display("[TB] FAIL rell_cnth got %h want 00", d); else pass_cnt++;
    bus_read(A_CNTL, d); check_cnt++; if (d !== 8'h10) $display("[TB] FAIL rell_wins got %h want 10", d); else pass_cnt++;
    peek(A_STAT, d); check_cnt++; if (d !== 8'h00) $display("[TB] FAIL rell_no_ovf got %h want 00", d); else pass_cnt++;
    bus_write(A_CTRL, 8'h00);
  endtask

`ifdef TIMERIO_CAPTURE_EN
  task automatic test_capture;
    logic [7:0]  d;
    logic [15:0] capv;
    bus_write(A_CTRL, 8'h18);
    peek(A_CTRL, d); check_cnt++; if (d !== 8'h18) $display("[TB] FAIL cap_cfg_bits got %h want 18", d); else pass_cnt++;
    bus_write(A_STAT, 8'h03);
    bus_write(A_PRESC, 8'h00);
    bus_write(A_RELH, 8'h01);
    bus_write(A_RELL, 8'h10);
    bus_write(A_CTRL, 8'h09);
    tick(16);
    cap_in = 1'b1;
    tick(5);
    bus_read(A_CAPH, d); capv[15:8] = d;
    bus_read(A_CAPL, d); capv[7:0]  = d;
    check_cnt++;
    if (capv < 16'h00FE || capv > 16'h0100) $display("[TB] FAIL cap_value got %h want 00FE..0100", capv);
    else pass_cnt++;
    peek(A_STAT, d); check_cnt++; if (d !== 8'h02) $display("[TB] FAIL cap_status got %h want 02", d); else pass_cnt++;
    check_cnt++; if (irq !== 1'b1) $display("[TB] FAIL cap_irq got %b want 1", irq); else pass_cnt++;
    bus_write(A_CTRL, 8'h00);
    bus_write(A_STAT, 8'h03);
    cap_in = 1'b0;
    tick(4);
  endtask
`else
  task automatic test_cap_masked;
    logic [7:0] d;
    bus_write(A_CTRL, 8'h18);
    peek(A_CTRL, d); check_cnt++; if (d !== 8'h00) $display("[TB] FAIL nocap_ctrl_bits got %h want 00", d); else pass_cnt++;
    peek(A_CAPH, d); check_cnt++; if (d !== 8'h00) $display("[TB] FAIL nocap_caph got %h want 00", d); else pass_cnt++;
    peek(A_CAPL, d); check_cnt++; if (d !== 8'h00) $display("[TB] FAIL nocap_capl got %h want 00", d); else pass_cnt++;
    tick(1);
  endtask
`endif

  task automatic test_async_reset;
    logic [7:0] d;
    bus_write(A_PRESC, 8'h00);
    bus_write(A_RELH, 8'h00);
    bus_write(A_RELL, 8'h02);
    bus_write(A_CTRL, 8'h03);
    tick(6);
    check_cnt++; if (irq !== 1'b1) $display("[TB] FAIL ar_irq_before got %b want 1", irq); else pass_cnt++;
    rst = 1'b0;
    #1;
    check_cnt++; if (irq !== 1'b0) $display("[TB] FAIL ar_irq_async got %b want 0", irq); else pass_cnt++;
    peek(A_CTRL, d); check_cnt++; if (d !== 8'h00) $display("[TB] FAIL ar_ctrl got %h want 00", d); else pass_cnt++;
    peek(A_RELH, d); check_cnt++; if (d !== 8'hFF) $display("[TB] FAIL ar_relh got %h want FF", d); else pass_cnt++;
    peek(A_RELL, d); check_cnt++; if (d !== 8'hFF) $display("[TB] FAIL ar_rell got %h want FF", d); else pass_cnt++;
    peek(A_CNTH, d); check_cnt++; if (d !== 8'h00) $display("[TB] FAIL ar_cnth got %h want 00", d); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    tick(1);
    bus_read(A_CNTL, d); check_cnt++; if (d !== 8'h00) $display("[TB] FAIL ar_cntl got %h want 00", d); else pass_cnt++;
    peek(A_STAT, d); check_cnt++; if (d !== 8'h00) $display("[TB] FAIL ar_status got %h want 00", d); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b0; cs = 1'b0; rw = 1'b1; AD = 4'd0; DI = 8'h00;
`ifdef TIMERIO_CAPTURE_EN
    cap_in = 1'b0;
`endif
    tick(2);
    rst = 1'b1;
    tick(1);
    test_reset();
    test_periodic();
    test_oneshot();
    test_w1c_collision();
    test_snapshot();
    test_rell_vs_tick();
`ifdef TIMERIO_CAPTURE_EN
    test_capture();
`else
    test_cap_masked();
`endif
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
